// File: rtl/rob_pkg.sv
// rob_pkg: ROB geometry and recovery FSM state encoding shared by the recovery controller.
package rob_pkg;
  localparam int ROB_IDX_W = 6;
  localparam int PR_W = 6;
  localparam int ROB_DEPTH = 64;
  typedef enum logic [1:0] {IDLE, WALK, DONE} rec_state_e;
endpackage

// File: rtl/rob_recovery_ctrl.sv
// rob_recovery_ctrl: walks the ROB from tail-1 back to the mispredicted branch, returning PRs to the free list.
// Optional RECOVERY_PERF_EN adds saturating recovery-count and walk-cycle performance counters.
module rob_recovery_ctrl
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mispredict,
  input  logic [ROB_IDX_W-1:0] mispred_rob_idx,
  input  logic [ROB_IDX_W-1:0] rob_tail,
  input  logic                 hazard_stall,
  output logic [ROB_IDX_W-1:0] rob_rd_idx,
  input  logic [PR_W-1:0]      rob_rd_pr_new,
  input  logic                 rob_rd_regdest,
  output logic                 recover,
  output logic [PR_W-1:0]      PR_new_flush,
  output logic                 RegDest_ROB,
  output logic                 decode_stall,
  output logic                 retire_block,
  output logic [ROB_IDX_W-1:0] rob_tail_restore,
  output logic                 rob_tail_restore_valid,
  output logic                 busy,
  output logic                 recover_done,
  output logic [15:0]          perf_recover_count,
  output logic [31:0]          perf_walk_cycles
);
  rec_state_e state, state_n;
  logic [ROB_IDX_W-1:0] cursor, cursor_n, target, target_n;
  logic accept, walk, done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cursor <= '0;
      target <= '0;
    end else begin
      state  <= state_n;
      cursor <= cursor_n;
      target <= target_n;
    end
  end
  // The youngest entry sits at tail-1; the walk stops after undoing target = branch+1.
  always_comb begin
    accept   = mispredict && state == IDLE;
    state_n  = state;
    cursor_n = cursor;
    target_n = target;
    if (accept) begin
      target_n = mispred_rob_idx + 6'd1;
      cursor_n = rob_tail - 6'd1;
      state_n  = rob_tail != target_n ? WALK : DONE;
    end else if (state == WALK && !hazard_stall) begin
      state_n  = cursor == target ? DONE : WALK;
      cursor_n = cursor == target ? cursor : cursor - 6'd1;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  assign walk                   = state == WALK;
  assign done                   = state == DONE;
  assign busy                   = state != IDLE;
  assign decode_stall           = accept | busy;
  assign retire_block           = busy;
  assign rob_rd_idx             = cursor;
  assign recover                = walk;
  assign PR_new_flush           = walk ? rob_rd_pr_new : '0;
  assign RegDest_ROB            = walk & rob_rd_regdest;
  assign rob_tail_restore_valid = done;
  assign recover_done           = done;
  assign rob_tail_restore       = done ? target : '0;
`ifdef RECOVERY_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_recover_count <= '0;
      perf_walk_cycles   <= '0;
    end else begin
      if (accept && !(&perf_recover_count)) perf_recover_count <= perf_recover_count + 16'd1;
      if (walk && !(&perf_walk_cycles)) perf_walk_cycles <= perf_walk_cycles + 32'd1;
    end
  end
`else
  assign perf_recover_count = '0;
  assign perf_walk_cycles   = '0;
`endif
endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// tb_rob_recovery_ctrl: directed and randomized checks of rob_recovery_ctrl against a queue-based reference model.
module tb_rob_recovery_ctrl;
  logic clk = 0, rst, mispredict, hazard_stall, rob_rd_regdest;
  logic [5:0] mispred_rob_idx, rob_tail, rob_rd_idx, rob_rd_pr_new, PR_new_flush, rob_tail_restore;
  logic recover, RegDest_ROB, decode_stall, retire_block, rob_tail_restore_valid, busy, recover_done;
  logic [15:0] perf_recover_count;
  logic [31:0] perf_walk_cycles;
  logic [5:0] mem_pr [64];
  logic mem_rd [64];
  int n_checks = 0, n_fail = 0;
  int mode = 0;
  int q[$];
  logic [5:0] m_target = 0;
  int m_pc = 0;
  longint m_wc = 0;
  int obs[$];
  int rd_at7 = -1, donec = 0, rest = -1;

  always #5 clk = ~clk;
  assign rob_rd_pr_new  = mem_pr[rob_rd_idx];
  assign rob_rd_regdest = mem_rd[rob_rd_idx];

  rob_recovery_ctrl dut (
    .clk(clk), .rst(rst), .mispredict(mispredict), .mispred_rob_idx(mispred_rob_idx),
    .rob_tail(rob_tail), .hazard_stall(hazard_stall), .rob_rd_idx(rob_rd_idx),
    .rob_rd_pr_new(rob_rd_pr_new), .rob_rd_regdest(rob_rd_regdest), .recover(recover),
    .PR_new_flush(PR_new_flush), .RegDest_ROB(RegDest_ROB), .decode_stall(decode_stall),
    .retire_block(retire_block), .rob_tail_restore(rob_tail_restore),
    .rob_tail_restore_valid(rob_tail_restore_valid), .busy(busy), .recover_done(recover_done),
    .perf_recover_count(perf_recover_count), .perf_walk_cycles(perf_walk_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit w, d;
    int cur;
    w = mode == 1;
    d = mode == 2;
    cur = w ? q[0] : 0;
    chk("recover", recover, w);
    chk("busy", busy, mode != 0);
    chk("retire_block", retire_block, mode != 0);
    chk("decode_stall", decode_stall, (mode == 0 && mispredict) || mode != 0);
    chk("PR_new_flush", PR_new_flush, w ? mem_pr[cur] : 6'd0);
    chk("RegDest_ROB", RegDest_ROB, w ? mem_rd[cur] : 1'b0);
    chk("restore_valid", rob_tail_restore_valid, d);
    chk("recover_done", recover_done, d);
    chk("tail_restore", rob_tail_restore, d ? m_target : 6'd0);
    if (w) chk("rob_rd_idx", rob_rd_idx, cur);
`ifdef RECOVERY_PERF_EN
    chk("perf_recover_count", perf_recover_count, m_pc);
    chk("perf_walk_cycles", perf_walk_cycles, m_wc[31:0]);
`else
    chk("perf_recover_count", perf_recover_count, 0);
    chk("perf_walk_cycles", perf_walk_cycles, 0);
`endif
  endtask

  task automatic model_step();
    int n;
    if (rst) begin
      mode = 0;
      q.delete();
      m_target = 0;
      m_pc = 0;
      m_wc = 0;
    end else if (mode == 0) begin
      if (mispredict) begin
        m_target = mispred_rob_idx + 6'd1;
        n = (((int'(rob_tail) - int'(mispred_rob_idx) - 1) % 64) + 64) % 64;
        for (int k = 0; k < n; k++) q.push_back((int'(rob_tail) - 1 - k + 64) % 64);
        mode = n != 0 ? 1 : 2;
        if (m_pc < 65535) m_pc++;
      end
    end else if (mode == 1) begin
      if (m_wc < 64'hFFFF_FFFF) m_wc++;
      if (!hazard_stall) begin
        void'(q.pop_front());
        if (q.size() == 0) mode = 2;
      end
    end else mode = 0;
  endtask

  task automatic cyc(input logic mp, input logic [5:0] idx, input logic [5:0] tl, input logic st, input logic r);
    mispredict = mp;
    mispred_rob_idx = idx;
    rob_tail = tl;
    hazard_stall = st;
    rst = r;
    #1;
    compare();
    if (recover) begin
      obs.push_back(int'(rob_rd_idx));
      if (rob_rd_idx == 6'd7) rd_at7 = int'(RegDest_ROB);
    end
    if (rob_tail_restore_valid) begin
      donec++;
      rest = int'(rob_tail_restore);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic scenario(input logic [5:0] idx, input logic [5:0] tl, input int stall_idx, input int stall_n,
                          input bit mp2, input int rst_at);
    int used = 0, k = 0;
    obs.delete();
    donec = 0;
    rest = -1;
    rd_at7 = -1;
    cyc(1, idx, tl, 0, 0);
    while (mode != 0 && k < 200) begin
      logic st;
      st = mode == 1 && q[0] == stall_idx && used < stall_n;
      if (st) used++;
      cyc(mp2 ? 1'($urandom % 2) : 1'b0, 6'($urandom), tl, st, k == rst_at);
      k++;
    end
    chk("scenario_bound", k < 200, 1);
    cyc(0, 0, tl, 0, 0);
  endtask

  task automatic check_walk(input string nm, input int exp[$], input int exp_rest);
    chk({nm, "_len"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++) chk({nm, "_idx"}, obs[i], exp[i]);
    chk({nm, "_restore"}, rest, exp_rest);
    chk({nm, "_done"}, donec, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_pr[i] = 6'($urandom);
      mem_rd[i] = 1'b1;
    end
    mem_rd[7] = 1'b0;
    rst = 1; mispredict = 0; mispred_rob_idx = 0; rob_tail = 0; hazard_stall = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_recover", recover, 0);
    chk("rst_rd_idx", rob_rd_idx, 0);
    chk("rst_restore_valid", rob_tail_restore_valid, 0);
    chk("rst_decode_stall", decode_stall, 0);
    rst = 0;
    scenario(6'd5, 6'd10, -1, 0, 0, -1);
    check_walk("basic", '{9, 8, 7, 6}, 6);
    chk("regdest_idx7", rd_at7, 0);
    scenario(6'd5, 6'd6, -1, 0, 0, -1);
    check_walk("direct", '{}, 6);
    scenario(6'd61, 6'd2, -1, 0, 0, -1);
    check_walk("wrap", '{1, 0, 63, 62}, 62);
    scenario(6'd5, 6'd10, 8, 2, 0, -1);
    check_walk("stall", '{9, 8, 8, 8, 7, 6}, 6);
    scenario(6'd5, 6'd10, -1, 0, 1, -1);
    check_walk("second_mp", '{9, 8, 7, 6}, 6);
    scenario(6'd5, 6'd10, -1, 0, 0, 1);
    chk("rst_mid_len", obs.size(), 2);
    chk("rst_mid_done", donec, 0);
    chk("rst_mid_recover", recover, 0);
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] idx;
      if (c % 200 == 0)
        for (int i = 0; i < 64; i++) begin
          mem_pr[i] = 6'($urandom);
          mem_rd[i] = 1'($urandom);
        end
      idx = 6'($urandom);
      cyc($urandom % 6 == 0, idx, idx + 6'd1 + 6'($urandom % 12), $urandom % 4 == 0, $urandom % 150 == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_recovery_ctrl.md
ROB_RECOVERY_CTRL -- requirements
Module: rob_recovery_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: mispredict  input  1  branch mispredict pulse from execute.
REQ-004 SHALL have port: mispred_rob_idx  input  6  ROB index of mispredicted branch.
REQ-005 SHALL have port: rob_tail  input  6  ROB next-write index.
REQ-006 SHALL have port: hazard_stall  input  1  global stall; free list ignores writes while high.
REQ-007 SHALL have port: rob_rd_idx  output  6  ROB read-port index (walk cursor).
REQ-008 SHALL have port: rob_rd_pr_new / rob_rd_regdest  input  6 / 1  ROB fields at rob_rd_idx, same cycle.
REQ-009 SHALL have port: recover  output  1  to free list, rollback write in progress.
REQ-010 SHALL have port: PR_new_flush / RegDest_ROB  output  6 / 1  PR and RegDest returned to free list.
REQ-011 SHALL have port: decode_stall / retire_block  output  1 / 1  hold decode; hold retire.
REQ-012 SHALL have port: rob_tail_restore  output  6  new ROB tail; rob_tail_restore_valid  output  1.
REQ-013 SHALL have port: busy  output  1  high when state != IDLE; recover_done  output  1  one-cycle pulse.

Function
REQ-014 SHALL implement FSM IDLE, WALK, DONE.
REQ-015 SHALL accept mispredict only in IDLE; mispredict while busy ignored (execute squashes younger branches itself).
REQ-016 On accept, SHALL latch target = mispred_rob_idx+1 mod 64, cursor = rob_tail-1 mod 64.
REQ-017 SHALL go IDLE->WALK if rob_tail != target, else IDLE->DONE (no younger entries).
REQ-018 In WALK, rob_rd_idx SHALL equal cursor; recover=1; PR_new_flush=rob_rd_pr_new; RegDest_ROB=rob_rd_regdest.
REQ-019 In WALK with hazard_stall=0, cursor SHALL decrement mod 64 (63 after 0); with hazard_stall=1, cursor and state SHALL hold.
REQ-020 WALK->DONE SHALL occur on the non-stalled cycle where cursor == target; entries walked = (rob_tail - mispred_rob_idx - 1) mod 64.
REQ-021 In DONE, SHALL assert rob_tail_restore_valid and recover_done for exactly one cycle with rob_tail_restore=target, then return to IDLE.
REQ-022 decode_stall SHALL equal mispredict_accepted OR busy (combinational on accept cycle).
REQ-023 retire_block SHALL equal busy.
REQ-024 Outside WALK, recover, RegDest_ROB SHALL be 0 and PR_new_flush SHALL be 0.

Reset
REQ-025 rst SHALL force IDLE, cursor=0, target=0; all outputs 0 next cycle.
REQ-026 rst during WALK SHALL abort the walk with no further recover cycles.

Configuration
REQ-027 With RECOVERY_PERF_EN defined, SHALL add outputs perf_recover_count (16b, increments per accepted mispredict, saturating) and perf_walk_cycles (32b, increments every WALK cycle incl. stalled, saturating), both reset to 0.
REQ-028 Without RECOVERY_PERF_EN, both perf ports SHALL exist and be tied to 0; no counter logic.

Structure
REQ-029 Package rob_pkg SHALL hold ROB_IDX_W=6, PR_W=6, ROB_DEPTH=64 and the FSM state enum.
REQ-030 SHALL be a single module; no sub-module is required.

Verification
REQ-031 tail=10, mispredict idx=5 -> WALK reads 9,8,7,6 (4 cycles recover=1), DONE rob_tail_restore=6, recover_done pulse.
REQ-032 tail=6, idx=5 -> IDLE->DONE directly, zero recover cycles, rob_tail_restore=6.
REQ-033 tail=2, idx=61 -> walk 1,0,63,62 (wrap), rob_tail_restore=62.
REQ-034 tail=10, idx=5, hazard_stall high 2 cycles during index 8 -> index 8 presented 3 cycles, total 6 WALK cycles, same restore.
REQ-035 Second mispredict during WALK -> ignored, walk completes unchanged; rst mid-WALK -> recover=0 next cycle, IDLE.
REQ-036 rob_rd_regdest=0 on index 7 -> RegDest_ROB=0 that cycle; free list tail unchanged for that entry.
